// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the fetch/decode decoupling queue.
package if_id_queue_pkg;

  localparam logic [31:0] NOOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ir;
    logic [3:0]  fwd;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_fifo_mem.sv
// DEPTH-entry bundle storage: one synchronous write port, one async read port.
module if_id_fifo_mem
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [AW-1:0] waddr_i,
  input  if_id_entry_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output if_id_entry_t rdata_o
);

  if_id_entry_t mem_q [DEPTH];

  // Contents need no reset: the queue never presents a slot it has not written.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// Fetch->decode decoupling FIFO with flush. Optional zero-latency path when
// the queue is empty is enabled by defining IF_ID_BYPASS_EN.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   if_PC_in,
  input  logic [31:0]   if_NPC_in,
  input  logic [31:0]   if_IR_in,
  input  logic          if_valid_in,
  input  logic [3:0]    if_forward_in,
  input  logic          id_stall,
  input  logic          flush,
  output logic          if_ready,
  output logic [31:0]   id_PC_out,
  output logic [31:0]   id_NPC_out,
  output logic [31:0]   id_IR_out,
  output logic          id_valid_out,
  output logic [3:0]    id_forward_out,
  output logic [CW-1:0] occupancy
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   held_pc_q, held_npc_q;
  if_id_entry_t  wr_entry, rd_entry, head;
  logic          empty, full, byp, enq, deq;

  assign wr_entry = '{pc: if_PC_in, npc: if_NPC_in, ir: if_IR_in, fwd: if_forward_in};
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign if_ready = ~full;

`ifdef IF_ID_BYPASS_EN
  assign byp = empty & if_valid_in & ~flush;
`else
  assign byp = 1'b0;
`endif

  // A bypassed bundle that decode takes immediately is never stored.
  assign enq = if_valid_in & if_ready & ~flush & ~(byp & ~id_stall);
  assign deq = ~empty & ~id_stall & ~flush;

  if_id_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (enq),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  assign head           = byp ? wr_entry : rd_entry;
  assign id_valid_out   = ~empty | byp;
  assign id_IR_out      = id_valid_out ? head.ir  : NOOP_INST;
  assign id_forward_out = id_valid_out ? head.fwd : 4'h0;
  assign id_PC_out      = id_valid_out ? head.pc  : held_pc_q;
  assign id_NPC_out     = id_valid_out ? head.npc : held_npc_q;
  assign occupancy      = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      if (enq && !deq)      count_d = count_q + CW'(1);
      else if (deq && !enq) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      held_pc_q  <= '0;
      held_npc_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // Remember the last presented head so PC/NPC stay stable once drained.
      if (id_valid_out) begin
        held_pc_q  <= head.pc;
        held_npc_q <= head.npc;
      end
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=2); bypass vectors
// are selected when IF_ID_BYPASS_EN is defined.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_PC_in, if_NPC_in, if_IR_in;
  logic        if_valid_in;
  logic [3:0]  if_forward_in;
  logic        id_stall, flush;
  logic        if_ready;
  logic [31:0] id_PC_out, id_NPC_out, id_IR_out;
  logic        id_valid_out;
  logic [3:0]  id_forward_out;
  logic [1:0]  occupancy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_PC_in       (if_PC_in),
    .if_NPC_in      (if_NPC_in),
    .if_IR_in       (if_IR_in),
    .if_valid_in    (if_valid_in),
    .if_forward_in  (if_forward_in),
    .id_stall       (id_stall),
    .flush          (flush),
    .if_ready       (if_ready),
    .id_PC_out      (id_PC_out),
    .id_NPC_out     (id_NPC_out),
    .id_IR_out      (id_IR_out),
    .id_valid_out   (id_valid_out),
    .id_forward_out (id_forward_out),
    .occupancy      (occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // Bundle fields derived from the PC so every field is distinguishable.
  task automatic offer(input logic v, input logic [31:0] pc, input logic st, input logic fl);
    if_valid_in   = v;
    if_PC_in      = pc;
    if_NPC_in     = pc + 32'd4;
    if_IR_in      = 32'hA000_0000 | pc;
    if_forward_in = pc[5:2];
    id_stall      = st;
    flush         = fl;
  endtask

  initial begin
    rst = 1'b1;
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    look();
    chk("rst_valid", 32'(id_valid_out), 32'd0);
    chk("rst_ir",    id_IR_out, 32'h0000_0013);
    chk("rst_ready", 32'(if_ready), 32'd1);
    chk("rst_occ",   32'(occupancy), 32'd0);
    chk("rst_pc",    id_PC_out, 32'h0);
    chk("rst_npc",   id_NPC_out, 32'h0);
    chk("rst_fwd",   32'(id_forward_out), 32'd0);

`ifdef IF_ID_BYPASS_EN
    // Empty queue, decode ready: same-cycle pass-through, nothing stored.
    offer(1'b1, 32'h40, 1'b0, 1'b0);
    #1;
    chk("byp_pc",    id_PC_out, 32'h40);
    chk("byp_valid", 32'(id_valid_out), 32'd1);
    chk("byp_ir",    id_IR_out, 32'hA000_0040);
    chk("byp_occ",   32'(occupancy), 32'd0);
    step();
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    look();
    chk("byp_occ_after", 32'(occupancy), 32'd0);
    // Stalled decode: bundle still visible now, and stored for later.
    offer(1'b1, 32'h44, 1'b1, 1'b0);
    #1;
    chk("byp_st_pc", id_PC_out, 32'h44);
    step();
    offer(1'b0, 32'h0, 1'b1, 1'b0);
    look();
    chk("byp_st_occ", 32'(occupancy), 32'd1);
    chk("byp_st_head", id_PC_out, 32'h44);
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    look();
    chk("byp_drain_occ",   32'(occupancy), 32'd0);
    chk("byp_drain_valid", 32'(id_valid_out), 32'd0);
    chk("byp_drain_held",  id_PC_out, 32'h44);
`else
    // Streaming with decode ready: one cycle latency, occupancy stays at 1.
    offer(1'b1, 32'h0, 1'b0, 1'b0);
    step();
    look();
    chk("str0_valid", 32'(id_valid_out), 32'd1);
    chk("str0_pc",    id_PC_out, 32'h0);
    chk("str0_ir",    id_IR_out, 32'hA000_0000);
    chk("str0_occ",   32'(occupancy), 32'd1);
    offer(1'b1, 32'h4, 1'b0, 1'b0);
    step();
    look();
    chk("str1_pc",  id_PC_out, 32'h4);
    chk("str1_npc", id_NPC_out, 32'h8);
    chk("str1_fwd", 32'(id_forward_out), 32'd1);
    chk("str1_occ", 32'(occupancy), 32'd1);
    offer(1'b1, 32'h8, 1'b0, 1'b0);
    step();
    look();
    chk("str2_pc",  id_PC_out, 32'h8);
    chk("str2_fwd", 32'(id_forward_out), 32'd2);
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    look();
    chk("str_empty_valid", 32'(id_valid_out), 32'd0);
    chk("str_empty_occ",   32'(occupancy), 32'd0);
    chk("str_empty_ir",    id_IR_out, 32'h0000_0013);
    chk("str_empty_fwd",   32'(id_forward_out), 32'd0);
    chk("str_held_pc",     id_PC_out, 32'h8);
    chk("str_held_npc",    id_NPC_out, 32'hC);

    // Stalled decode: fills at 2, third bundle refused.
    offer(1'b1, 32'h10, 1'b1, 1'b0);
    step();
    look();
    chk("st1_occ",   32'(occupancy), 32'd1);
    chk("st1_ready", 32'(if_ready), 32'd1);
    offer(1'b1, 32'h14, 1'b1, 1'b0);
    step();
    look();
    chk("st2_occ",   32'(occupancy), 32'd2);
    chk("st2_ready", 32'(if_ready), 32'd0);
    offer(1'b1, 32'h18, 1'b1, 1'b0);
    step();
    look();
    chk("st3_occ",  32'(occupancy), 32'd2);
    chk("st3_head", id_PC_out, 32'h10);
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    look();
    chk("rel1_head",  id_PC_out, 32'h14);
    chk("rel1_occ",   32'(occupancy), 32'd1);
    chk("rel1_ready", 32'(if_ready), 32'd1);
    step();
    look();
    chk("rel2_occ",   32'(occupancy), 32'd0);
    chk("rel2_valid", 32'(id_valid_out), 32'd0);

    // Flush with a valid input on the same cycle: all dropped.
    offer(1'b1, 32'h20, 1'b1, 1'b0);
    step();
    offer(1'b1, 32'h24, 1'b1, 1'b0);
    step();
    look();
    chk("fl_pre_occ", 32'(occupancy), 32'd2);
    offer(1'b1, 32'h28, 1'b1, 1'b1);
    step();
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    look();
    chk("fl_occ",   32'(occupancy), 32'd0);
    chk("fl_valid", 32'(id_valid_out), 32'd0);
    chk("fl_ready", 32'(if_ready), 32'd1);
    chk("fl_held",  id_PC_out, 32'h20);
    step();
    look();
    chk("fl_dropped_occ", 32'(occupancy), 32'd0);

    // Full plus simultaneous dequeue: input still refused.
    offer(1'b1, 32'h30, 1'b1, 1'b0);
    step();
    offer(1'b1, 32'h34, 1'b1, 1'b0);
    step();
    look();
    chk("fd_pre_occ", 32'(occupancy), 32'd2);
    offer(1'b1, 32'h38, 1'b0, 1'b0);
    step();
    look();
    chk("fd_occ",  32'(occupancy), 32'd1);
    chk("fd_head", id_PC_out, 32'h34);
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    look();
    chk("fd_not_written", 32'(occupancy), 32'd0);

    // Ten bundles in order across several pointer wraps.
    for (int i = 0; i < 10; i++) begin
      offer(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
      step();
      look();
      chk($sformatf("wrap%0d_pc", i), id_PC_out, 32'h100 + 32'(4 * i));
      chk($sformatf("wrap%0d_occ", i), 32'(occupancy), 32'd1);
    end

    // Reset mid-operation clears the queue and the held PC/NPC.
    offer(1'b1, 32'h50, 1'b1, 1'b0);
    step();
    offer(1'b0, 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    look();
    chk("mrst_occ", 32'(occupancy), 32'd0);
    chk("mrst_pc",  id_PC_out, 32'h0);
    chk("mrst_npc", id_NPC_out, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
